// File: rtl/uart_frame_tx.sv
// UART frame transmitter: latches a 24-bit payload on a start request and sends
// an 8N1 five-byte frame (header, three payload bytes MSB-first, checksum).
module uart_frame_tx #(
    parameter int          CLK_FREQ = 50_000_000,
    parameter int          BAUD     = 115200,
    parameter logic [7:0]  HEADER   = 8'hAA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [23:0] payload,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [2:0]        byte_idx;
    logic [23:0]       data_q;
    logic [7:0]        chk_q;
    logic [7:0]        cur_byte;
    logic              bit_end;

    // Byte currently on the wire, selected by its position in the frame
    always_comb begin
        cur_byte = HEADER;
        case (byte_idx)
            3'd1:    cur_byte = data_q[23:16];
            3'd2:    cur_byte = data_q[15:8];
            3'd3:    cur_byte = data_q[7:0];
            3'd4:    cur_byte = chk_q;
            default: cur_byte = HEADER;
        endcase
    end

    assign bit_end = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            data_q   <= '0;
            chk_q    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (send) begin
                        data_q <= payload;
                        chk_q  <= payload[23:16] + payload[15:8] + payload[7:0];
                        state  <= START;
                        tx     <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx       <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        // Last stop bit ends the frame; otherwise the next start bit follows at once
                        if (byte_idx == 3'd4) begin
                            byte_idx <= '0;
                            state    <= IDLE;
                            tx       <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= START;
                            tx       <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed self-checking bench for uart_frame_tx at 10 clocks per bit.
module tb_uart_frame_tx;

    localparam int BC = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [23:0] payload;
    logic        tx;
    logic        busy;
    logic        done;

    int passed = 0;
    int total  = 0;

    uart_frame_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .HEADER   (8'hAA)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .send    (send),
        .payload (payload),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at #1 after a rising edge while idle; returns in the first start-bit cycle
    task automatic send_frame(input logic [23:0] p);
        send    = 1'b1;
        payload = p;
        @(posedge clk); #1;
        send    = 1'b0;
    endtask

    // Samples 50 bit periods from the first start-bit cycle; returns in the done cycle
    task automatic capture_frame(input int hold_cycles, output logic [39:0] frame,
                                 output int glitches, output int framing, output int busy_bad);
        frame    = '0;
        glitches = 0;
        framing  = 0;
        busy_bad = 0;
        for (int b = 0; b < 50; b++) begin
            logic v;
            int   j;
            int   k;
            v = tx;
            for (int c = 0; c < BC; c++) begin
                if (tx !== v) glitches++;
                if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
                if (b * BC + c < hold_cycles) begin
                    send    = 1'b1;
                    payload = 24'hABCDEF;
                end else begin
                    send = 1'b0;
                end
                @(posedge clk); #1;
            end
            j = b % 10;
            k = b / 10;
            if (j == 0) begin
                if (v !== 1'b0) framing++;
            end else if (j == 9) begin
                if (v !== 1'b1) framing++;
            end else begin
                frame[32 - 8 * k + j - 1] = v;
            end
        end
        send = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        send    = 1'b0;
        payload = '0;
        #12;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL reset_state: got tx=%b busy=%b done=%b, expected 1 0 0", tx, busy, done);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        total++;
        if (bad != 0) $display("[TB] FAIL idle_quiet: got %0d bad cycles, expected 0", bad);
        else passed++;
    endtask

    task automatic test_basic();
        logic [39:0] fr;
        int g, f, bb;
        send_frame(24'h123456);
        total++;
        if (tx !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL basic_latency: got tx=%b busy=%b, expected 0 1", tx, busy);
        else passed++;
        capture_frame(0, fr, g, f, bb);
        total++;
        if (fr !== 40'hAA1234569C) $display("[TB] FAIL basic_frame: got %h expected AA1234569C", fr);
        else passed++;
        total++;
        if (g != 0) $display("[TB] FAIL basic_bit_timing: got %0d glitches, expected 0", g);
        else passed++;
        total++;
        if (f != 0) $display("[TB] FAIL basic_framing: got %0d bad start/stop bits, expected 0", f);
        else passed++;
        total++;
        if (bb != 0) $display("[TB] FAIL basic_busy: got %0d cycles busy low or done high, expected 0", bb);
        else passed++;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1)
            $display("[TB] FAIL basic_done_cycle: got done=%b busy=%b tx=%b, expected 1 0 1", done, busy, tx);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) $display("[TB] FAIL basic_done_width: got done=%b, expected 0", done);
        else passed++;
    endtask

    task automatic test_checksum();
        logic [39:0] fr;
        int g, f, bb;
        send_frame(24'hFFFFFF);
        capture_frame(0, fr, g, f, bb);
        total++;
        if (fr !== 40'hAAFFFFFFFD || g != 0 || f != 0)
            $display("[TB] FAIL chk_ones: got %h g=%0d f=%0d, expected AAFFFFFFFD 0 0", fr, g, f);
        else passed++;
        @(posedge clk); #1;
        send_frame(24'h000000);
        capture_frame(0, fr, g, f, bb);
        total++;
        if (fr !== 40'hAA00000000 || g != 0 || f != 0)
            $display("[TB] FAIL chk_zeros: got %h g=%0d f=%0d, expected AA00000000 0 0", fr, g, f);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_send_ignored();
        logic [39:0] fr;
        int g, f, bb;
        int bad = 0;
        send_frame(24'h123456);
        capture_frame(200, fr, g, f, bb);
        total++;
        if (fr !== 40'hAA1234569C || bb != 0)
            $display("[TB] FAIL busy_ignore: got %h busy_bad=%0d, expected AA1234569C 0", fr, bb);
        else passed++;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("[TB] FAIL no_second_frame: got %0d active cycles, expected 0", bad);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [39:0] fr;
        int g, f, bb;
        send_frame(24'h123456);
        capture_frame(0, fr, g, f, bb);
        send    = 1'b1;
        payload = 24'h010203;
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL b2b_done: got done=%b busy=%b, expected 1 0", done, busy);
        else passed++;
        @(posedge clk); #1;
        send = 1'b0;
        total++;
        if (tx !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL b2b_start: got tx=%b busy=%b, expected 0 1", tx, busy);
        else passed++;
        capture_frame(0, fr, g, f, bb);
        total++;
        if (fr !== 40'hAA01020306 || g != 0 || f != 0 || bb != 0)
            $display("[TB] FAIL b2b_frame: got %h g=%0d f=%0d bb=%0d, expected AA01020306 0 0 0", fr, g, f, bb);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [39:0] fr;
        int g, f, bb;
        int bad = 0;
        send_frame(24'h123456);
        repeat (243) @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL mid_before_rst: got tx=%b busy=%b, expected 0 1", tx, busy);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL mid_rst_immediate: got tx=%b busy=%b done=%b, expected 1 0 0", tx, busy, done);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("[TB] FAIL mid_rst_hold: got %0d active cycles, expected 0", bad);
        else passed++;
        send_frame(24'hC0FFEE);
        capture_frame(0, fr, g, f, bb);
        total++;
        if (fr !== 40'hAAC0FFEEAD || g != 0 || f != 0 || bb != 0 || done !== 1'b1)
            $display("[TB] FAIL mid_rst_recover: got %h g=%0d f=%0d bb=%0d done=%b, expected AAC0FFEEAD 0 0 0 1",
                     fr, g, f, bb, done);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_checksum();
        test_send_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
